bias_relu_fire6_squeeze: RTL and testbench
==========================================

BIAS_RELU_FIRE6_SQUEEZE -- requirements
Module: bias_relu_fire6_squeeze

Interface -- parameters
REQ-001 SHALL: CHANNELS, 64, output channels per pixel; one bias word per channel.
REQ-002 SHALL: PIXELS, 169, pixels per feature map (13x13).
REQ-003 SHALL: SHIFT, 4, arithmetic right-shift applied after bias add.
REQ-004 SHALL: OUT_W, 16, output data width, signed.

Interface -- ports
REQ-005 SHALL: clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL: bias_mem  in  32 x [0:CHANNELS-1]  signed bias words from the fire6_squeeze bias ROM, static.
REQ-008 SHALL: start  in  1  one-cycle pulse that begins a feature map.
REQ-009 SHALL: acc_in  in  32  signed accumulator value for the current (pixel, channel).
REQ-010 SHALL: acc_valid / acc_ready  in / out  1 each  input handshake.
REQ-011 SHALL: out_data  out  OUT_W  biased, ReLU'd, shifted, saturated result.
REQ-012 SHALL: out_ch  out  6  channel index of out_data.
REQ-013 SHALL: out_valid / out_ready  out / in  1 each  output handshake; out_last  out  1  final beat of the map.
REQ-014 SHALL: busy  out  1  high in RUN or FLUSH; done  out  1  one-cycle pulse when the map completes.

Function
REQ-015 SHALL: FSM states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start; RUN->FLUSH on the last input transfer; FLUSH->DONE when the pipeline is empty; DONE->IDLE after exactly one cycle.
REQ-016 SHALL: start is ignored outside IDLE; entering RUN clears ch_cnt and pix_cnt to 0.
REQ-017 SHALL: input order is channel-major within a pixel: ch 0..CHANNELS-1, then the next pixel.
REQ-018 SHALL: transfer occurs when acc_valid && acc_ready; ch_cnt increments per transfer and wraps CHANNELS-1->0 while incrementing pix_cnt.
REQ-019 SHALL: last input transfer = pix_cnt==PIXELS-1 && ch_cnt==CHANNELS-1.
REQ-020 SHALL: pipeline has 2 stages. S1: sum = sext33(acc_in) + sext33(bias_mem[ch_cnt]). S2: ReLU (sum<0 -> 0), then sum>>>SHIFT, then clamp to 2^(OUT_W-1)-1.
REQ-021 SHALL: enable en = !out_valid || out_ready; both stages and acc_ready advance only with en; acc_ready = en && state==RUN.
REQ-022 SHALL: latency is 2 cycles from input transfer to out_valid with out_ready held high; full throughput is 1 beat/cycle.
REQ-023 SHALL: out_data, out_ch and out_last are held stable while out_valid && !out_ready.
REQ-024 SHALL: out_last is asserted only with the beat carrying pixel PIXELS-1, channel CHANNELS-1.
REQ-025 SHALL: done asserts in the DONE cycle, which is after the out_last transfer completes.
REQ-026 SHALL: the sum is never truncated before saturation; the 33-bit sum covers all 32-bit operand pairs.

Reset
REQ-027 SHALL: on rst the FSM goes to IDLE; ch_cnt, pix_cnt and both stage valids go to 0.
REQ-028 SHALL: on rst out_valid, out_last, busy, done, acc_ready, out_data and out_ch all go to 0.
REQ-029 SHALL: rst mid-map discards all in-flight data; the next map requires a new start.

Verification
REQ-030 SHALL: bias[0]=-18, start, acc_in=100 at ch0, out_ready=1 -> out_data=5 (82>>>4), out_ch=0, out_valid 2 cycles after transfer.
REQ-031 SHALL: bias[3]=-80, acc_in=50 at ch3 -> out_data=0 (ReLU); bias[34]=1344, acc_in=0 at ch34 -> out_data=84.
REQ-032 SHALL: bias[1]=172, acc_in=0x7FFFFFFF at ch1 -> out_data=32767 (saturated, no wrap).
REQ-033 SHALL: full 169x64 map with random out_ready backpressure -> exactly 10816 outputs in order; out_last only on the final one; done 1 cycle after it; no beat lost or duplicated.
REQ-034 SHALL: rst asserted after 100 transfers -> next cycle IDLE with all outputs 0; a new start restarts at pixel 0, ch 0.
REQ-035 SHALL: start pulsed during RUN -> ignored; counters and output stream unchanged.

Source files
------------

// File: rtl/bias_relu_fire6_squeeze.sv
// Bias-add, ReLU, arithmetic shift and saturation for the fire6 squeeze layer.
// Two-stage pipeline with valid/ready handshakes and map-level start/done control.
module bias_relu_fire6_squeeze #(
  parameter int CHANNELS = 64,
  parameter int PIXELS   = 169,
  parameter int SHIFT    = 4,
  parameter int OUT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [31:0]      bias_mem [0:CHANNELS-1],
  input  logic                    start,
  input  logic signed [31:0]      acc_in,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [5:0]              out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = $clog2(CHANNELS);
  localparam int PW = $clog2(PIXELS + 1);
  localparam logic signed [32:0] MAXV = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_ch;
  logic [PW-1:0]           r_pix;
  logic                    r_busy;
  logic                    r_done;

  logic                    r_s1_valid;
  logic signed [32:0]      r_s1_sum;
  logic [CW-1:0]           r_s1_ch;
  logic                    r_s1_last;

  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic [5:0]              r_out_ch;
  logic                    r_out_last;

  logic                    w_en;
  logic                    w_xfer;
  logic                    w_last_in;
  logic signed [31:0]      w_bias;
  logic signed [32:0]      w_sum;
  logic signed [32:0]      w_sh;
  logic signed [OUT_W-1:0] w_sat;

  assign w_en      = !r_out_valid || out_ready;
  assign acc_ready = w_en && (r_state == S_RUN);
  assign w_xfer    = acc_valid && acc_ready;
  assign w_last_in = (r_pix == PW'(PIXELS - 1)) && (r_ch == CW'(CHANNELS - 1));
  assign w_bias    = bias_mem[r_ch];
  // 33-bit sum: no 32-bit operand pair can overflow it.
  assign w_sum     = {acc_in[31], acc_in} + {w_bias[31], w_bias};
  assign w_sh      = r_s1_sum >>> SHIFT;

  always_comb begin
    w_sat = '0;
    if (r_s1_sum[32]) begin
      w_sat = '0;
    end else if (w_sh > MAXV) begin
      w_sat = MAXV[OUT_W-1:0];
    end else begin
      w_sat = w_sh[OUT_W-1:0];
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_pix       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_sum    <= '0;
      r_s1_ch     <= '0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_en) begin
        r_s1_valid <= w_xfer;
        if (w_xfer) begin
          r_s1_sum  <= w_sum;
          r_s1_ch   <= r_ch;
          r_s1_last <= w_last_in;
        end
        r_out_valid <= r_s1_valid;
        r_out_last  <= r_s1_valid && r_s1_last;
        if (r_s1_valid) begin
          r_out_data <= w_sat;
          r_out_ch   <= 6'(r_s1_ch);
        end
      end

      if (w_xfer) begin
        if (r_ch == CW'(CHANNELS - 1)) begin
          r_ch  <= '0;
          r_pix <= r_pix + PW'(1);
        end else begin
          r_ch <= r_ch + CW'(1);
        end
      end

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_ch    <= '0;
            r_pix   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_xfer && w_last_in) r_state <= S_FLUSH;
        end
        // Empty once stage 1 is idle and the output beat is gone or leaving now.
        S_FLUSH: begin
          if (!r_s1_valid && w_en) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bias_relu_fire6_squeeze.sv
// Bench for bias_relu_fire6_squeeze: scoreboard of expected beats from the
// arithmetic definition, plus literal expectations for the directed pixel.
module tb_bias_relu_fire6_squeeze;
  localparam int CH    = 64;
  localparam int PIX   = 169;
  localparam int TOTAL = CH * PIX;

  logic clk = 1'b0;
  logic rst, start, acc_valid, acc_ready, out_valid, out_ready, out_last, busy, done;
  logic signed [31:0] acc_in;
  logic signed [31:0] bias [0:CH-1];
  logic signed [15:0] out_data;
  logic [5:0]         out_ch;

  bias_relu_fire6_squeeze #(.CHANNELS(CH), .PIXELS(PIX), .SHIFT(4), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .bias_mem(bias), .start(start),
    .acc_in(acc_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      2: out_ready = 1'($urandom_range(1));
      default: out_ready = ($urandom_range(3) != 0);
    endcase
  end

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic: (acc + bias), clip negatives, divide by 16, cap at 32767.
  function automatic logic signed [15:0] model(longint a, longint b);
    longint s;
    s = a + b;
    if (s < 0) return 16'sd0;
    s = s / 16;
    if (s > 32767) s = 32767;
    return 16'(s);
  endfunction

  typedef struct {
    logic signed [15:0] d;
    int                 ch;
    bit                 last;
    int                 idx;
  } beat_t;

  beat_t q[$];
  int m_n = 0;
  int pops = 0;
  int exp_done_cyc = -1;
  int t_x0 = 0;
  bit lat_pend = 0;
  logic signed [15:0] lit [0:CH-1];
  logic stall_p = 1'b0;
  logic signed [15:0] d_p;
  logic [5:0] ch_p;
  logic last_p;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      q.delete();
      m_n = 0;
      lat_pend = 0;
      stall_p = 1'b0;
      exp_done_cyc = -1;
    end else begin
      if (stall_p) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, d_p);
        chk("hold_ch", out_ch, ch_p);
        chk("hold_last", out_last, last_p);
      end
      if (lat_pend && out_valid) begin
        chk("latency", cyc - t_x0, 2);
        lat_pend = 0;
      end
      if (!out_valid) chk("last_without_valid", out_last, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_beat_queue_size", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("data", out_data, e.d);
          chk("ch", out_ch, e.ch);
          chk("last", out_last, e.last);
          pops++;
          if (e.idx < CH) lit[e.idx] = out_data;
          if (e.last) exp_done_cyc = cyc + 1;
        end
      end
      if (cyc == exp_done_cyc) begin
        chk("done", done, 1);
        chk("busy_at_done", busy, 0);
        exp_done_cyc = -1;
      end else begin
        chk("done_spurious", done, 0);
      end
      if (acc_valid && acc_ready) begin
        e.d    = model(acc_in, bias[m_n % CH]);
        e.ch   = m_n % CH;
        e.last = (m_n == TOTAL - 1);
        e.idx  = m_n;
        q.push_back(e);
        if (m_n == 0) begin
          t_x0 = cyc;
          lat_pend = 1;
        end
        m_n++;
      end
      stall_p = out_valid && !out_ready;
      d_p = out_data;
      ch_p = out_ch;
      last_p = out_last;
    end
  end

  function automatic logic signed [31:0] rand_acc();
    case ($urandom_range(3))
      0: return $signed(32'($urandom_range(4000))) - 32'sd2000;
      1: return $signed(32'h7FFF_FF00 + 32'($urandom_range(255)));
      2: return $signed(32'h8000_0000 + 32'($urandom_range(255)));
      default: return $signed($urandom);
    endcase
  endfunction

  function automatic logic signed [31:0] dir_acc(int i);
    case (i)
      0: return 32'sd100;
      1: return 32'sh7FFF_FFFF;
      3: return 32'sd50;
      34: return 32'sd0;
      default: return rand_acc();
    endcase
  endfunction

  // Drives n transfers; the first 64 are gapless when directed, later ones random-gapped.
  task automatic feed(int n, bit directed, int pulse_at);
    bit ok;
    int g;
    for (int i = 0; i < n; i++) begin
      if (!(directed && i < CH) && $urandom_range(3) == 0) begin
        acc_valid = 1'b0;
        @(posedge clk); #1;
      end
      acc_in = directed ? dir_acc(i) : rand_acc();
      acc_valid = 1'b1;
      if (i == pulse_at) start = 1'b1;
      g = 0;
      do begin
        @(negedge clk);
        ok = acc_ready;
        @(posedge clk); #1;
        start = 1'b0;
        g++;
      end while (!ok && g < 1000);
      if (!ok) begin
        chk("feed_timeout", ok, 1);
        acc_valid = 1'b0;
        return;
      end
      if (i == pulse_at) chk("busy_after_ignored_start", busy, 1);
      if (directed && i == CH - 1) rdy_mode = 2;
    end
    acc_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!done && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("done_timeout", (g < 5000) ? 1 : 0, 1);
    @(posedge clk); #1;
    chk("idle_done_low", done, 0);
    chk("idle_busy_low", busy, 0);
  endtask

  task automatic check_zero_outputs(string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_acc_ready"}, acc_ready, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_ch"}, out_ch, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; acc_valid = 1'b0; acc_in = '0; out_ready = 1'b0;
    for (int i = 0; i < CH; i++) bias[i] = $signed($urandom);
    bias[0] = -32'sd18;
    bias[1] = 32'sd172;
    bias[3] = -32'sd80;
    bias[34] = 32'sd1344;
    for (int i = 4; i < 12; i++) bias[i] = $signed(32'($urandom_range(3000))) - 32'sd1500;

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Map 1: directed pixel 0, then random backpressure, stray start mid-map.
    rdy_mode = 1;
    pops = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_in_run", busy, 1);
    feed(TOTAL, 1'b1, 500);
    wait_done();
    chk("lit_ch0", lit[0], 5);
    chk("lit_ch1_saturate", lit[1], 32767);
    chk("lit_ch3_relu", lit[3], 0);
    chk("lit_ch34", lit[34], 84);
    chk("map1_beats", pops, TOTAL);
    chk("map1_queue_empty", q.size(), 0);

    // Map 2: aborted by reset after 100 transfers.
    rdy_mode = 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(100, 1'b0, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("midreset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero_outputs("after_reset_idle");

    // Map 3: fresh start must restart at pixel 0, channel 0.
    pops = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(TOTAL, 1'b0, -1);
    wait_done();
    chk("map3_beats", pops, TOTAL);
    chk("map3_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
